// File: rtl/ppu_stat_irq_unit.sv
// PPU interrupt unit: edge-detects enable-masked STAT sources and VBlank entry, emits
// one-clock interrupt pulses (optionally delayed) and keeps sticky per-source pending flags.
module ppu_stat_irq_unit #(
  parameter int NUM_SRC   = 4,
  parameter int LINE_MODE = 1,
  parameter int DELAY     = 0,
  localparam int ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic               ppu_enable,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic [NUM_SRC-1:0] src_level,
  input  logic [1:0]         mode,
  output logic               vblank_int,
  output logic               ppu_int,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               clr_we,
  input  logic [NUM_SRC-1:0] clr_mask
);

  logic [NUM_SRC-1:0] line;
  logic [NUM_SRC-1:0] line_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pending_nxt;
  logic               vb;
  logic               vb_prev;
  logic               vb_rise;
  logic               stat_edge;
  logic               stat_out;
  logic               vb_out;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    line    = src_enable & src_level;
    vb      = (mode == 2'd1);
    rise    = ppu_enable ? (line & ~line_prev) : '0;
    vb_rise = ppu_enable & vb & ~vb_prev;

    // Shared-line mode: a rise hidden behind an already-high source gives no edge.
    if (LINE_MODE != 0) stat_edge = ppu_enable & (|line) & ~(|line_prev);
    else                stat_edge = |rise;

    irq_req = |pending;
    irq_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) irq_id = ID_W'(i);
    end

    clr = '0;
    if (irq_ack && irq_req) clr = NUM_SRC'(1) << irq_id;
    if (clr_we)             clr = clr | clr_mask;
    pending_nxt = (pending & ~clr) | (stat_edge ? rise : '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_prev <= '0;
      vb_prev   <= 1'b0;
      pending   <= '0;
    end else if (cpu_en) begin
      // History tracks the levels even while the PPU is off, so re-enabling
      // with a level already high is not an edge.
      line_prev <= line;
      vb_prev   <= vb;
      pending   <= pending_nxt;
    end
  end

  generate
    if (DELAY == 0) begin : g_no_delay
      assign stat_out = stat_edge;
      assign vb_out   = vb_rise;
    end else begin : g_delay
      logic [DELAY-1:0] stat_pipe;
      logic [DELAY-1:0] vb_pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stat_pipe <= '0;
          vb_pipe   <= '0;
        end else if (cpu_en) begin
          if (!ppu_enable) begin
            stat_pipe <= '0;
            vb_pipe   <= '0;
          end else begin
            stat_pipe <= (stat_pipe << 1) | DELAY'(stat_edge);
            vb_pipe   <= (vb_pipe << 1) | DELAY'(vb_rise);
          end
        end
      end

      assign stat_out = ppu_enable & stat_pipe[DELAY-1];
      assign vb_out   = ppu_enable & vb_pipe[DELAY-1];
    end
  endgenerate

  // Pulse registers are rewritten every clock, so a pulse never outlives one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ppu_int    <= 1'b0;
      vblank_int <= 1'b0;
    end else begin
      ppu_int    <= cpu_en & stat_out;
      vblank_int <= cpu_en & vb_out;
    end
  end

endmodule

// File: tb/tb_ppu_stat_irq_unit.sv
// Directed bench for ppu_stat_irq_unit: shared-line (a), per-source (b) and
// two-tick-delay (c) instances driven from the same inputs.
module tb_ppu_stat_irq_unit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_en;
  logic         ppu_enable;
  logic [N-1:0] src_enable;
  logic [N-1:0] src_level;
  logic [1:0]   mode;
  logic         irq_ack;
  logic         clr_we;
  logic [N-1:0] clr_mask;

  logic         a_vb, a_int, a_req, b_vb, b_int, b_req, c_vb, c_int, c_req;
  logic [N-1:0] a_pend, b_pend, c_pend;
  logic [1:0]   a_id, b_id, c_id;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ppu_stat_irq_unit #(.NUM_SRC(N), .LINE_MODE(1), .DELAY(0)) dut_a (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .ppu_enable(ppu_enable),
    .src_enable(src_enable), .src_level(src_level), .mode(mode),
    .vblank_int(a_vb), .ppu_int(a_int), .pending(a_pend), .irq_req(a_req),
    .irq_id(a_id), .irq_ack(irq_ack), .clr_we(clr_we), .clr_mask(clr_mask));

  ppu_stat_irq_unit #(.NUM_SRC(N), .LINE_MODE(0), .DELAY(0)) dut_b (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .ppu_enable(ppu_enable),
    .src_enable(src_enable), .src_level(src_level), .mode(mode),
    .vblank_int(b_vb), .ppu_int(b_int), .pending(b_pend), .irq_req(b_req),
    .irq_id(b_id), .irq_ack(irq_ack), .clr_we(clr_we), .clr_mask(clr_mask));

  ppu_stat_irq_unit #(.NUM_SRC(N), .LINE_MODE(1), .DELAY(2)) dut_c (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .ppu_enable(ppu_enable),
    .src_enable(src_enable), .src_level(src_level), .mode(mode),
    .vblank_int(c_vb), .ppu_int(c_int), .pending(c_pend), .irq_req(c_req),
    .irq_id(c_id), .irq_ack(irq_ack), .clr_we(clr_we), .clr_mask(clr_mask));

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] lvl;
    logic [1:0]   md;
    logic         ack;
    logic         cwe;
    logic [N-1:0] cmask;
    logic         pe;
    logic         e_int_a;
    logic [N-1:0] e_pend_a;
    logic         e_req;
    logic [1:0]   e_id;
    logic         e_vb;
    logic         e_int_b;
    logic [N-1:0] e_pend_b;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_en     = 1'b1;
    ppu_enable = 1'b1;
    src_enable = '0;
    src_level  = '0;
    mode       = 2'd0;
    irq_ack    = 1'b0;
    clr_we     = 1'b0;
    clr_mask   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    //           en       lvl      md  ack cwe cmask    pe  int_a pend_a  req id  vb  int_b pend_b
    vecs[0]  = '{4'b0001, 4'b0000, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[1]  = '{4'b0001, 4'b0001, 2'd0, 0, 0, 4'b0000, 1, 1, 4'b0001, 1, 2'd0, 0, 1, 4'b0001};
    vecs[2]  = '{4'b1001, 4'b0001, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0001, 1, 2'd0, 0, 0, 4'b0001};
    vecs[3]  = '{4'b1001, 4'b1001, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0001, 1, 2'd0, 0, 1, 4'b1001};
    vecs[4]  = '{4'b1001, 4'b1001, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0001, 1, 2'd0, 0, 0, 4'b1001};
    vecs[5]  = '{4'b1001, 4'b0000, 2'd1, 0, 0, 4'b0000, 1, 0, 4'b0001, 1, 2'd0, 1, 0, 4'b1001};
    vecs[6]  = '{4'b1001, 4'b0000, 2'd1, 0, 0, 4'b0000, 1, 0, 4'b0001, 1, 2'd0, 0, 0, 4'b1001};
    vecs[7]  = '{4'b1001, 4'b0000, 2'd0, 0, 1, 4'b1111, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[8]  = '{4'b0110, 4'b0110, 2'd0, 0, 0, 4'b0000, 1, 1, 4'b0110, 1, 2'd1, 0, 1, 4'b0110};
    vecs[9]  = '{4'b0110, 4'b0110, 2'd0, 1, 0, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 0, 0, 4'b0100};
    vecs[10] = '{4'b0110, 4'b0110, 2'd0, 1, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[11] = '{4'b0110, 4'b0000, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[12] = '{4'b0110, 4'b0100, 2'd0, 0, 0, 4'b0000, 1, 1, 4'b0100, 1, 2'd2, 0, 1, 4'b0100};
    vecs[13] = '{4'b0110, 4'b0000, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0100, 1, 2'd2, 0, 0, 4'b0100};
    vecs[14] = '{4'b0110, 4'b0100, 2'd0, 1, 0, 4'b0000, 1, 1, 4'b0100, 1, 2'd2, 0, 1, 4'b0100};
    vecs[15] = '{4'b0110, 4'b0000, 2'd0, 0, 1, 4'b0100, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[16] = '{4'b0110, 4'b0100, 2'd0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[17] = '{4'b0110, 4'b0100, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[18] = '{4'b0110, 4'b0000, 2'd0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0, 4'b0000};
    vecs[19] = '{4'b0110, 4'b0100, 2'd0, 0, 0, 4'b0000, 1, 1, 4'b0100, 1, 2'd2, 0, 1, 4'b0100};

    idle_inputs();
    reset = 1'b1;
    step();
    check("reset_ppu_int",    {a_int, b_int, c_int}, 0);
    check("reset_vblank_int", {a_vb, b_vb, c_vb}, 0);
    check("reset_pending",    {a_pend, b_pend, c_pend}, 0);
    check("reset_irq",        {a_req, a_id}, 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      src_enable = vecs[i].en;
      src_level  = vecs[i].lvl;
      mode       = vecs[i].md;
      irq_ack    = vecs[i].ack;
      clr_we     = vecs[i].cwe;
      clr_mask   = vecs[i].cmask;
      ppu_enable = vecs[i].pe;
      step();
      check($sformatf("v%0d_ppu_int_a", i), a_int, vecs[i].e_int_a);
      check($sformatf("v%0d_pending_a", i), a_pend, vecs[i].e_pend_a);
      check($sformatf("v%0d_irq_req", i), a_req, vecs[i].e_req);
      check($sformatf("v%0d_irq_id", i), a_id, vecs[i].e_id);
      check($sformatf("v%0d_vblank_int", i), a_vb, vecs[i].e_vb);
      check($sformatf("v%0d_ppu_int_b", i), b_int, vecs[i].e_int_b);
      check($sformatf("v%0d_pending_b", i), b_pend, vecs[i].e_pend_b);
    end

    // Delayed pulses with a sparse tick: edge on tick at k=0, pulse after tick at k=8.
    idle_inputs();
    src_enable = 4'b0001;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      cpu_en = (k % 4 == 0);
      if (k == 0) begin
        src_level = 4'b0001;
        mode      = 2'd1;
      end
      step();
      check($sformatf("delay_ppu_int_k%0d", k), c_int, (k == 8));
      check($sformatf("delay_vblank_int_k%0d", k), c_vb, (k == 8));
    end

    // Reset landing after the second tick drops the in-flight pulse.
    idle_inputs();
    src_enable = 4'b0001;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cpu_en = (k % 4 == 0);
      reset  = (k == 5 || k == 6);
      if (k == 0) begin
        src_level = 4'b0001;
        mode      = 2'd1;
      end else if (k >= 5) begin
        src_level = 4'b0000;
        mode      = 2'd0;
      end
      step();
      check($sformatf("rst_drop_ppu_int_k%0d", k), c_int, 0);
      check($sformatf("rst_drop_vblank_int_k%0d", k), c_vb, 0);
    end
    reset = 1'b0;

    // Held cpu_en low after an edge: pulse lasts one clk, state frozen meanwhile.
    idle_inputs();
    src_enable = 4'b0010;
    do_reset();
    src_level = 4'b0010;
    step();
    check("hold_pulse", a_int, 1);
    cpu_en    = 1'b0;
    src_level = 4'b0000;
    step();
    check("hold_pulse_drop", a_int, 0);
    src_level = 4'b0010;
    step();
    check("frozen_no_edge", a_int, 0);
    check("frozen_pending", a_pend, 4'b0010);
    check("frozen_irq_id", a_id, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
